game_flow_controller: RTL and testbench
=======================================

# game_flow_controller

Top-level game sequencer for the gatorga display pipeline. It owns the life count, level number and play/pause/game-over phases. It also issues frame-aligned object resets to the paddle, ball and alien blocks. It consumes loss and win events from the object controllers and the vertical frame-sync pulse. It drives the enable and overlay-select signals that the top-level pixel mux and the game-over renderer use.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded at game start (1..7)
- SERVE_FRAMES, 60: frames held in SERVE before play resumes (>=1)
- PAUSE_FRAMES, 90: frames held in LIFE_LOST / LEVEL_UP (>=1)
- GAMEOVER_FRAMES, 180: frames held in GAME_OVER before returning to IDLE (>=1)
- LEVEL_MAX, 15: saturation value of level (<=15)

Ports:
- pixel_clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- fsync  in  1  one-cycle pulse at start of each frame
- start_btn  in  1  debounced start request, level-sensitive
- ball_lost  in  1  one-cycle pulse: ball passed the paddle
- alien_reached_paddle  in  1  level: an alien touched the paddle row
- aliens_cleared  in  1  one-cycle pulse: last alien destroyed
- state  out  3  IDLE=0, SERVE=1, PLAY=2, LIFE_LOST=3, LEVEL_UP=4, GAME_OVER=5
- play_enable  out  1  high only in PLAY; gates object motion
- obj_reset  out  1  one-cycle pulse that re-initialises object positions
- game_over  out  1  high only in GAME_OVER; selects game-over overlay
- lives  out  3  remaining lives
- level  out  4  current level, starting at 1

## Operation
- All outputs are registered. On rst: state=IDLE, play_enable=0, obj_reset=0, game_over=0, lives=LIVES_INIT, level=1, frame_cnt=0.
- frame_cnt is cleared on every state transition. In SERVE, LIFE_LOST, LEVEL_UP and GAME_OVER it increments on fsync. The exit fires on the fsync seen while frame_cnt==N-1, so a state is held for exactly N fsyncs.
- IDLE: start_btn=1 -> SERVE. Same edge: lives=LIVES_INIT, level=1, obj_reset=1.
- SERVE: after SERVE_FRAMES -> PLAY. Events are ignored.
- PLAY: play_enable=1. Event priority in one cycle:
  - alien_reached_paddle -> GAME_OVER, lives=0.
  - Else ball_lost: if lives==1 -> GAME_OVER with lives=0; otherwise lives-1 and -> LIFE_LOST.
  - Else aliens_cleared -> LEVEL_UP, level=min(level+1, LEVEL_MAX).
  - fsync in the same cycle as an event has no additional effect.
- LIFE_LOST / LEVEL_UP: after PAUSE_FRAMES -> SERVE with obj_reset=1 on the transition edge. lives and level are unchanged.
- GAME_OVER: game_over=1. start_btn and all events are ignored. After GAMEOVER_FRAMES -> IDLE. lives stays 0 until the next start.
- In every non-PLAY state, ball_lost, aliens_cleared and alien_reached_paddle are ignored.
- Unused state encodings 6 and 7 recover to IDLE on the next clock.
- lives arithmetic is 3-bit unsigned and never underflows. level is 4-bit and saturates.

## Timing
- Event-to-output latency is 1 clock: the state, lives, level, play_enable and game_over change on the edge after the input cycle.
- obj_reset is high for exactly one pixel_clk, coincident with the first cycle of the new SERVE state.
- Pause durations are frame-accurate. SERVE lasts SERVE_FRAMES fsyncs plus the partial frame before the first fsync.
- Asserting rst mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge. Operation resumes in IDLE on the first clock after release.

## Test plan
All scenarios use LIVES_INIT=3, SERVE_FRAMES=2, PAUSE_FRAMES=3, GAMEOVER_FRAMES=4.
- Start: from reset, start_btn=1 -> next clock state=1, obj_reset pulses once. After 2 fsyncs state=2 and play_enable=1.
- Life loss: in PLAY, ball_lost pulse -> lives=2, state=3. After 3 fsyncs obj_reset pulses and state=1. After 2 more fsyncs state=2.
- Last life: with lives=1 in PLAY, ball_lost -> lives=0, state=5, game_over=1. After 4 fsyncs state=0 and game_over=0. start_btn held during GAME_OVER has no effect.
- Simultaneous events: ball_lost, aliens_cleared and alien_reached_paddle all asserted in one PLAY cycle with lives=3 -> state=5, lives=0, level unchanged.
- Level saturation: repeated aliens_cleared with level=15 -> state=4, level stays 15. Events during LEVEL_UP are ignored; lives is unchanged.
- Reset mid-pause: rst asserted asynchronously in LIFE_LOST between clock edges -> outputs reach IDLE values before the next edge. After release with no start_btn, state stays 0.

Source files
------------

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - game phase sequencer: lives, level, frame-timed pauses, object resets
module game_flow_controller #(
    parameter int LIVES_INIT      = 3,
    parameter int SERVE_FRAMES    = 60,
    parameter int PAUSE_FRAMES    = 90,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int LEVEL_MAX       = 15
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       fsync,
    input  logic       start_btn,
    input  logic       ball_lost,
    input  logic       alien_reached_paddle,
    input  logic       aliens_cleared,
    output logic [2:0] state,
    output logic       play_enable,
    output logic       obj_reset,
    output logic       game_over,
    output logic [2:0] lives,
    output logic [3:0] level
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        LIFE_LOST = 3'd3,
        LEVEL_UP  = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam int MAX_AB     = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > GAMEOVER_FRAMES) ? MAX_AB : GAMEOVER_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES + 1) : 1;

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(GAMEOVER_FRAMES - 1);
    localparam logic [2:0]       LIVES_START = 3'(LIVES_INIT);
    localparam logic [3:0]       LEVEL_TOP   = 4'(LEVEL_MAX);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       lives_nxt;
    logic [3:0]       level_nxt;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            cur         <= IDLE;
            frame_cnt   <= '0;
            lives       <= LIVES_START;
            level       <= 4'd1;
            play_enable <= 1'b0;
            obj_reset   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            cur         <= nxt;
            frame_cnt   <= cnt_nxt;
            lives       <= lives_nxt;
            level       <= level_nxt;
            play_enable <= (nxt == PLAY);
            game_over   <= (nxt == GAME_OVER);
            // Pulse only on the edge that enters SERVE, never while holding in it.
            obj_reset   <= (nxt == SERVE) && (cur != SERVE);
        end
    end

    always_comb begin
        nxt       = cur;
        cnt_nxt   = frame_cnt;
        lives_nxt = lives;
        level_nxt = level;
        case (cur)
            IDLE: begin
                if (start_btn) begin
                    nxt       = SERVE;
                    lives_nxt = LIVES_START;
                    level_nxt = 4'd1;
                end
            end
            SERVE: begin
                if (fsync) begin
                    if (frame_cnt == SERVE_LAST) nxt = PLAY;
                    else cnt_nxt = frame_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (alien_reached_paddle) begin
                    nxt       = GAME_OVER;
                    lives_nxt = '0;
                end else if (ball_lost) begin
                    // lives <= 1 also covers a zero count so the subtract cannot wrap.
                    if (lives <= 3'd1) begin
                        nxt       = GAME_OVER;
                        lives_nxt = '0;
                    end else begin
                        nxt       = LIFE_LOST;
                        lives_nxt = lives - 3'd1;
                    end
                end else if (aliens_cleared) begin
                    nxt = LEVEL_UP;
                    if (level < LEVEL_TOP) level_nxt = level + 4'd1;
                end
            end
            LIFE_LOST, LEVEL_UP: begin
                if (fsync) begin
                    if (frame_cnt == PAUSE_LAST) nxt = SERVE;
                    else cnt_nxt = frame_cnt + 1'b1;
                end
            end
            GAME_OVER: begin
                if (fsync) begin
                    if (frame_cnt == OVER_LAST) nxt = IDLE;
                    else cnt_nxt = frame_cnt + 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        if (nxt != cur) cnt_nxt = '0;
    end

    assign state = cur;

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - scoreboard bench for game_flow_controller
module tb_game_flow_controller;

    logic       pixel_clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsync = 1'b0;
    logic       start_btn = 1'b0;
    logic       ball_lost = 1'b0;
    logic       alien_reached_paddle = 1'b0;
    logic       aliens_cleared = 1'b0;
    logic [2:0] state;
    logic       play_enable;
    logic       obj_reset;
    logic       game_over;
    logic [2:0] lives;
    logic [3:0] level;

    always #5 pixel_clk = ~pixel_clk;

    game_flow_controller #(
        .LIVES_INIT(3), .SERVE_FRAMES(2), .PAUSE_FRAMES(3), .GAMEOVER_FRAMES(4), .LEVEL_MAX(15)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .start_btn(start_btn),
        .ball_lost(ball_lost), .alien_reached_paddle(alien_reached_paddle),
        .aliens_cleared(aliens_cleared), .state(state), .play_enable(play_enable),
        .obj_reset(obj_reset), .game_over(game_over), .lives(lives), .level(level)
    );

    // {state, play_enable, obj_reset, game_over, lives, level}
    typedef struct packed {
        logic [2:0] st;
        logic       pe;
        logic       orst;
        logic       go;
        logic [2:0] lv;
        logic [3:0] lvl;
    } snap_t;

    typedef struct {
        snap_t s;
        int    fs;
    } exp_t;

    exp_t       sb[$];
    int         compared = 0;
    int         mismatched = 0;
    int         fs_total = 0;
    int         orst_seen = 0;
    int         orst_exp = 0;
    logic [2:0] prev_state = 3'd0;

    task automatic expect_out(input int st, input int pe, input int orst, input int go,
                              input int lv, input int lvl, input int fs_ofs);
        exp_t e;
        e.s  = {3'(st), 1'(pe), 1'(orst), 1'(go), 3'(lv), 4'(lvl)};
        e.fs = fs_total + fs_ofs;
        if (orst != 0) orst_exp++;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pixel_clk); #1;
            fsync = 1'b1;
            fs_total++;
            @(posedge pixel_clk); #1;
            fsync = 1'b0;
            repeat (3) @(posedge pixel_clk);
        end
    endtask

    task automatic hit(input logic s, input logic b, input logic c, input logic a);
        @(posedge pixel_clk); #1;
        start_btn = s; ball_lost = b; aliens_cleared = c; alien_reached_paddle = a;
        @(posedge pixel_clk); #1;
        start_btn = 1'b0; ball_lost = 1'b0; aliens_cleared = 1'b0; alien_reached_paddle = 1'b0;
    endtask

    // Every state change pops one expected snapshot, including the fsync count at that moment.
    always @(negedge pixel_clk) begin
        snap_t act;
        exp_t  e;
        act = {state, play_enable, obj_reset, game_over, lives, level};
        if (obj_reset) orst_seen++;
        if (state !== prev_state) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change: state %0d with no expected entry", state);
            end else begin
                e = sb.pop_front();
                if (act !== e.s) begin
                    mismatched++;
                    $display("FAIL outputs: got st=%0d pe=%0d or=%0d go=%0d lives=%0d level=%0d expected st=%0d pe=%0d or=%0d go=%0d lives=%0d level=%0d",
                             act.st, act.pe, act.orst, act.go, act.lv, act.lvl,
                             e.s.st, e.s.pe, e.s.orst, e.s.go, e.s.lv, e.s.lvl);
                end
                compared++;
                if (fs_total != e.fs) begin
                    mismatched++;
                    $display("FAIL frame_timing: state %0d entered after %0d fsyncs expected %0d",
                             state, fs_total, e.fs);
                end
            end
        end
        prev_state = state;
    end

    initial begin
        repeat (3) @(posedge pixel_clk); #1;
        check("reset_state", int'(state), 0);
        check("reset_lives", int'(lives), 3);
        check("reset_level", int'(level), 1);
        check("reset_flags", int'({play_enable, obj_reset, game_over}), 0);
        rst = 1'b0;
        repeat (2) @(posedge pixel_clk);

        // start: SERVE for 2 fsyncs then PLAY
        expect_out(1, 0, 1, 0, 3, 1, 0);
        expect_out(2, 1, 0, 0, 3, 1, 2);
        hit(1'b1, 1'b0, 1'b0, 1'b0);
        frames(2);
        frames(2);

        // life loss, with events in SERVE ignored
        expect_out(3, 0, 0, 0, 2, 1, 0);
        expect_out(1, 0, 1, 0, 2, 1, 3);
        expect_out(2, 1, 0, 0, 2, 1, 5);
        hit(1'b0, 1'b1, 1'b0, 1'b0);
        frames(3);
        hit(1'b0, 1'b1, 1'b1, 1'b1);
        frames(2);

        // climb to level 15
        for (int lv = 2; lv <= 15; lv++) begin
            expect_out(4, 0, 0, 0, 2, lv, 0);
            expect_out(1, 0, 1, 0, 2, lv, 3);
            expect_out(2, 1, 0, 0, 2, lv, 5);
            hit(1'b0, 1'b0, 1'b1, 1'b0);
            if (lv == 2) hit(1'b0, 1'b1, 1'b0, 1'b1);
            frames(5);
        end

        // saturation, events during LEVEL_UP ignored
        expect_out(4, 0, 0, 0, 2, 15, 0);
        expect_out(1, 0, 1, 0, 2, 15, 3);
        expect_out(2, 1, 0, 0, 2, 15, 5);
        hit(1'b0, 1'b0, 1'b1, 1'b0);
        hit(1'b0, 1'b1, 1'b0, 1'b1);
        hit(1'b0, 1'b0, 1'b1, 1'b0);
        frames(5);

        // down to the last life
        expect_out(3, 0, 0, 0, 1, 15, 0);
        expect_out(1, 0, 1, 0, 1, 15, 3);
        expect_out(2, 1, 0, 0, 1, 15, 5);
        hit(1'b0, 1'b1, 1'b0, 1'b0);
        frames(5);

        // last life lost, start held during GAME_OVER
        expect_out(5, 0, 0, 1, 0, 15, 0);
        expect_out(0, 0, 0, 0, 0, 15, 4);
        hit(1'b0, 1'b1, 1'b0, 1'b0);
        start_btn = 1'b1;
        frames(3);
        @(posedge pixel_clk); #1;
        start_btn = 1'b0;
        frames(1);
        repeat (5) @(posedge pixel_clk);

        // restart, then all three events at once
        expect_out(1, 0, 1, 0, 3, 1, 0);
        expect_out(2, 1, 0, 0, 3, 1, 2);
        hit(1'b1, 1'b0, 1'b0, 1'b0);
        frames(2);
        expect_out(5, 0, 0, 1, 0, 1, 0);
        expect_out(0, 0, 0, 0, 0, 1, 4);
        hit(1'b0, 1'b1, 1'b1, 1'b1);
        frames(4);

        // asynchronous reset in LIFE_LOST
        expect_out(1, 0, 1, 0, 3, 1, 0);
        expect_out(2, 1, 0, 0, 3, 1, 2);
        hit(1'b1, 1'b0, 1'b0, 1'b0);
        frames(2);
        expect_out(3, 0, 0, 0, 2, 1, 0);
        hit(1'b0, 1'b1, 1'b0, 1'b0);
        frames(1);
        expect_out(0, 0, 0, 0, 3, 1, 0);
        @(posedge pixel_clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_lives", int'(lives), 3);
        check("async_rst_level", int'(level), 1);
        repeat (2) @(posedge pixel_clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge pixel_clk); #1;
        check("idle_after_release", int'(state), 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge pixel_clk);
        check("scoreboard_drained", sb.size(), 0);
        check("obj_reset_cycles", orst_seen, orst_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
